// File: rtl/iir_filter_mc.sv
// iir_filter_mc
// Multi-channel first-order IIR filter: y[n] = x[n] + ((a * y[n-1]) >>> FRAC_W).
// Each of CHANNELS time-multiplexed channels keeps its own y[n-1] state.
// A single output register with a combinational in_ready gives full
// throughput under valid/ready flow control.
//
// Optional feature macro: IIR_SAT_EN
//   defined   -> results are clamped to the DATA_W signed range and any clamp
//                sets the sticky sat_flag (cleared by rst or clr)
//   undefined -> results wrap to DATA_W bits and sat_flag is tied to 0
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   clr                   synchronous clear of all channel states and sat_flag
//   coef_a                signed feedback coefficient, used at input accept
//   in_valid/in_ready     input handshake
//   in_ch, in_x           input channel index and signed sample
//   out_valid/out_ready   output handshake
//   out_ch, out_y         output channel index and signed result
//   sat_flag              sticky overflow indicator
module iir_filter_mc #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int FRAC_W   = 6,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic signed [COEF_W-1:0] coef_a,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] out_y,
    output logic                     sat_flag
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = PROD_W + 1;

    logic signed [DATA_W-1:0] y_prev_q [CHANNELS];
    logic signed [DATA_W-1:0] y_prev_d [CHANNELS];
    logic                     out_valid_q, out_valid_d;
    logic [CH_W-1:0]          out_ch_q, out_ch_d;
    logic signed [DATA_W-1:0] out_y_q, out_y_d;

    logic                     accept;
    logic                     ch_ok;
    logic                     take;
    logic signed [DATA_W-1:0] y_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] sh;
    logic signed [DATA_W-1:0] result;

`ifdef IIR_SAT_EN
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SUM_MIN = ~SUM_MAX;

    logic signed [SUM_W-1:0] sum;
    logic                    clamp;
    logic                    sat_flag_q, sat_flag_d;
`endif

    // Handshake and datapath. A clear in the accept cycle makes the sample
    // see a zero history, so the state mux is forced to zero under clr.
    always_comb begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        ch_ok    = 32'(in_ch) < CHANNELS;
        take     = accept && ch_ok;

        y_sel = '0;
        if (!clr) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (in_ch == CH_W'(i)) begin
                    y_sel = y_prev_q[i];
                end
            end
        end

        prod = PROD_W'(coef_a) * PROD_W'(y_sel);
        // Arithmetic shift floors toward minus infinity.
        sh   = prod >>> FRAC_W;

`ifdef IIR_SAT_EN
        sum   = SUM_W'(in_x) + SUM_W'(sh);
        clamp = 1'b0;
        if (sum > SUM_MAX) begin
            result = SUM_MAX[DATA_W-1:0];
            clamp  = 1'b1;
        end else if (sum < SUM_MIN) begin
            result = SUM_MIN[DATA_W-1:0];
            clamp  = 1'b1;
        end else begin
            result = sum[DATA_W-1:0];
        end
`else
        result = DATA_W'(SUM_W'(in_x) + SUM_W'(sh));
`endif
    end

    // Next-state for channel history and the output register. Samples on an
    // out-of-range channel are swallowed without touching any state.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            y_prev_d[i] = clr ? '0 : y_prev_q[i];
            if (take && (in_ch == CH_W'(i))) begin
                y_prev_d[i] = result;
            end
        end

        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_y_d     = out_y_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_ch_d    = in_ch;
            out_y_d     = result;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

`ifdef IIR_SAT_EN
        sat_flag_d = (clr ? 1'b0 : sat_flag_q) | (take && clamp);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                y_prev_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_y_q     <= '0;
`ifdef IIR_SAT_EN
            sat_flag_q  <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                y_prev_q[i] <= y_prev_d[i];
            end
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_y_q     <= out_y_d;
`ifdef IIR_SAT_EN
            sat_flag_q  <= sat_flag_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_y     = out_y_q;
`ifdef IIR_SAT_EN
    assign sat_flag  = sat_flag_q;
`else
    assign sat_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_iir_filter_mc.sv
// tb_iir_filter_mc
// Directed bench for iir_filter_mc built with CHANNELS=3 so that channel 3 is
// out of range. Expected results are hand-computed and queued when a sample
// is issued; an independent monitor pops them whenever the DUT hands off a
// result.
module tb_iir_filter_mc;

    localparam int DATA_W   = 8;
    localparam int COEF_W   = 8;
    localparam int FRAC_W   = 6;
    localparam int CHANNELS = 3;
    localparam int CH_W     = 2;

`ifdef IIR_SAT_EN
    localparam int OVF2    = 127;
    localparam int OVF3    = 127;
    localparam int SAT_EXP = 1;
`else
    localparam int OVF2    = -56;
    localparam int OVF3    = 44;
    localparam int SAT_EXP = 0;
`endif

    typedef struct packed {
        logic [CH_W-1:0]          ch;
        logic signed [DATA_W-1:0] y;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     clr;
    logic signed [COEF_W-1:0] coef_a;
    logic                     in_valid;
    logic                     in_ready;
    logic [CH_W-1:0]          in_ch;
    logic signed [DATA_W-1:0] in_x;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] out_y;
    logic                     sat_flag;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    iir_filter_mc #(
        .DATA_W  (DATA_W),
        .COEF_W  (COEF_W),
        .FRAC_W  (FRAC_W),
        .CHANNELS(CHANNELS),
        .CH_W    (CH_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .coef_a   (coef_a),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ch    (in_ch),
        .in_x     (in_x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch   (out_ch),
        .out_y    (out_y),
        .sat_flag (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Inputs change just after the rising edge so they are stable for the
    // whole following cycle.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one sample and waits for it to be accepted. When expect_out is
    // set the hand-computed result is queued for the monitor.
    task automatic applyStimulus(input int ch, input int x, input int a,
                                 input bit clr_in, input bit expect_out, input int exp_y);
        exp_t e;
        bit   acc;
        in_ch    = ch[CH_W-1:0];
        in_x     = x[DATA_W-1:0];
        coef_a   = a[COEF_W-1:0];
        clr      = clr_in;
        in_valid = 1'b1;
        if (expect_out) begin
            e.ch = ch[CH_W-1:0];
            e.y  = exp_y[DATA_W-1:0];
            exp_q.push_back(e);
        end
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            stepCycle();
        end
        if (!acc) begin
            checkOutput("accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic waitDrain();
        int k;
        k = 0;
        while (k < 100 && (exp_q.size() != 0 || out_valid)) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            checkOutput("drain_timeout", exp_q.size(), 0);
        end
        stepCycle();
    endtask

    // Scoreboard monitor: every completed output handshake must match the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_output: got ch=%0d y=%0d, expected none",
                         out_ch, out_y);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_ch", int'(out_ch), int'(e.ch));
                checkOutput("out_y", int'(out_y), int'(e.y));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        coef_a    = '0;
        in_valid  = 1'b0;
        in_ch     = '0;
        in_x      = '0;
        out_ready = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_out_valid", int'(out_valid), 0);
        checkOutput("reset_out_y", int'(out_y), 0);
        checkOutput("reset_out_ch", int'(out_ch), 0);
        checkOutput("reset_sat_flag", int'(sat_flag), 0);
        checkOutput("reset_in_ready", int'(in_ready), 1);
        stepCycle();

        // Step response on channel 0 with a = 0.5.
        applyStimulus(0, 16, 32, 0, 1, 16);
        applyStimulus(0, 16, 32, 0, 1, 24);
        applyStimulus(0, 16, 32, 0, 1, 28);
        applyStimulus(0, 16, 32, 0, 1, 30);
        applyStimulus(0, 16, 32, 0, 1, 31);
        applyStimulus(0, 16, 32, 0, 1, 31);
        waitDrain();

        // Overflow on channel 1 with a = 1.0.
        applyStimulus(1, 100, 64, 0, 1, 100);
        applyStimulus(1, 100, 64, 0, 1, OVF2);
        applyStimulus(1, 100, 64, 0, 1, OVF3);
        waitDrain();
        @(negedge clk);
        checkOutput("sat_flag_after_overflow", int'(sat_flag), SAT_EXP);
        stepCycle();
        clr = 1'b1;
        stepCycle();
        clr = 1'b0;
        @(negedge clk);
        checkOutput("sat_flag_after_clr", int'(sat_flag), 0);
        stepCycle();

        // Negative floor rounding on channel 2.
        applyStimulus(2, -3, 32, 0, 1, -3);
        applyStimulus(2, 0, 32, 0, 1, -2);

        // Channel isolation, plus an out-of-range channel that must vanish.
        applyStimulus(0, 16, 32, 0, 1, 16);
        applyStimulus(1, 8, 32, 0, 1, 8);
        applyStimulus(0, 16, 32, 0, 1, 24);
        applyStimulus(1, 8, 32, 0, 1, 12);
        applyStimulus(3, 50, 32, 0, 0, 0);
        applyStimulus(0, 16, 32, 0, 1, 28);
        waitDrain();

        // Backpressure: one result held while a second sample waits.
        out_ready = 1'b0;
        applyStimulus(1, 0, 32, 0, 1, 6);
        in_ch    = 2'd0;
        in_x     = '0;
        coef_a   = 8'sd32;
        in_valid = 1'b1;
        begin
            exp_t e;
            e.ch = 2'd0;
            e.y  = 8'sd14;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("hold_in_ready", int'(in_ready), 0);
            checkOutput("hold_out_valid", int'(out_valid), 1);
            checkOutput("hold_out_y", int'(out_y), 6);
            checkOutput("hold_out_ch", int'(out_ch), 1);
            stepCycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_in_ready", int'(in_ready), 1);
        stepCycle();
        in_valid = 1'b0;
        waitDrain();

        // Reset while a result is pending; a sample during reset is dropped.
        out_ready = 1'b0;
        applyStimulus(0, 4, 32, 0, 0, 0);
        rst      = 1'b1;
        in_ch    = 2'd2;
        in_x     = 8'sd50;
        coef_a   = 8'sd32;
        in_valid = 1'b1;
        stepCycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midreset_out_valid", int'(out_valid), 0);
        checkOutput("midreset_out_y", int'(out_y), 0);
        stepCycle();
        out_ready = 1'b1;
        applyStimulus(0, 16, 32, 0, 1, 16);
        applyStimulus(2, 0, 32, 0, 1, 0);

        // clr together with an accept.
        applyStimulus(1, 8, 32, 0, 1, 8);
        applyStimulus(1, 8, 32, 0, 1, 12);
        applyStimulus(0, 20, 32, 1, 1, 20);
        applyStimulus(1, 8, 32, 0, 1, 8);
        applyStimulus(0, 0, 32, 0, 1, 10);

        // Coefficient changes between samples.
        applyStimulus(0, 0, 64, 0, 1, 10);
        applyStimulus(0, 5, -64, 0, 1, -5);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iir_filter_mc.md
Name: iir_filter_mc

Overview:
- Parametrised, multi-channel successor to the 4-bit first-order IIR filter.
- Computes y[n] = x[n] + ((a * y[n-1]) >>> FRAC_W) on signed fixed-point data.
- Keeps independent y[n-1] state for up to CHANNELS time-multiplexed channels.
- Uses a valid/ready handshake on input and output; sits between a sample source (ADC/deserialiser) and downstream DSP.

Parameters:
- DATA_W, 8: signed sample and output width.
- COEF_W, 8: signed coefficient width.
- FRAC_W, 6: coefficient fractional bits (a = 2^FRAC_W is gain 1.0).
- CHANNELS, 4: number of independent channel states (1..2^CH_W).
- CH_W, 2: channel index width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of all channel states and the sticky flag.
- coef_a  in  COEF_W  signed feedback coefficient; sampled on input accept.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_ch  in  CH_W  channel of the input sample.
- in_x  in  DATA_W  signed input sample.
- out_valid  out  1  output result valid.
- out_ready  in  1  downstream accepts the result.
- out_ch  out  CH_W  channel of the output result.
- out_y  out  DATA_W  signed filter output.
- sat_flag  out  1  sticky overflow indicator.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - Clears out_valid, out_ch, out_y, sat_flag and all y_prev[0..CHANNELS-1] to 0.
  - A sample presented in the reset cycle is dropped.
- Accept: when in_valid && in_ready.
- in_ready = !out_valid || out_ready.
  - It is combinational from out_ready, giving a single output register with full throughput.
- Compute in the accept cycle, combinationally from the current y_prev[in_ch]:
  - prod = coef_a * y_prev[in_ch], full width DATA_W+COEF_W.
  - sh = prod >>> FRAC_W, arithmetic shift with floor rounding.
  - sum = in_x + sh, computed at DATA_W+COEF_W+1 bits with no intermediate loss.
  - The result is then range-reduced to DATA_W (see Optional Feature).
- Latency: out_valid asserts the cycle after accept. Result registers update on the accept edge:
  - out_y is loaded with the result.
  - out_ch is loaded with in_ch.
  - y_prev[in_ch] is loaded with the result.
- Output hold:
  - While out_valid && !out_ready, out_y and out_ch stay stable and no accept occurs.
  - out_valid clears on out_ready unless a new accept happens in the same cycle.
- Back-to-back samples:
  - Samples on the same channel in consecutive cycles are legal.
  - y_prev is written on the accept edge, so the next sample reads the updated value. No forwarding hazard exists.
- Invalid channel (in_ch >= CHANNELS):
  - The sample is accepted and discarded.
  - No output, no state change, out_valid unaffected.
- clr:
  - Zeroes all y_prev and sat_flag in the next cycle.
  - Output registers are unaffected.
  - clr with an accept in the same cycle: the sample uses y_prev = 0 and its result is written to its channel; all other channels are zeroed.
- rst has priority over clr and accept.
- coef_a may change any cycle; each sample uses the value present at its accept.

Optional Feature:
- Macro: IIR_SAT_EN.
- Defined:
  - sum is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Any clamp sets sat_flag, which stays high until rst or clr.
  - The clamped value is both the output and the stored state.
- Undefined:
  - sum is truncated to its low DATA_W bits (two's-complement wrap).
  - sat_flag is tied to 0.

Test Plan:
- Step response: a=32, x=16 repeatedly on ch0, out_ready=1 -> out_y = 16, 24, 28, 30, 31, 31; out_valid one cycle after each accept.
- Overflow: a=64, x=100 twice on ch1.
  - With IIR_SAT_EN -> 100, then 127, sat_flag=1 until clr.
  - Without it -> 100, then -56; a third x=100 gives 44.
- Negative floor: a=32 on ch2, x=-3 then x=0 -> out_y = -3, then -2.
- Channel isolation: alternate ch0 x=16 and ch1 x=8, a=32 -> ch0 gives 16, 24 and ch1 gives 8, 12; in_ch=3 with CHANNELS=3 gives no output.
- Backpressure: hold out_ready=0 after one result -> in_ready=0, out_y/out_ch stable for 5 cycles; on release, the next queued sample is accepted the same cycle.
- Reset and clr mid-stream: rst while out_valid=1 -> out_valid=0 and ch0 state 0, so the next x=16 with a=32 gives 16. clr with a simultaneous accept -> result equals in_x, other channels restart from 0.
